// File: rtl/regfile_axil_ctrl.sv
// AXI4-Lite slave that sequences bus traffic onto a single-port 3-entry register
// file and runs an r0+r1 add, controlled through a status word at word 3.
module regfile_axil_ctrl #(
  parameter int CALC_CYCLES = 1
) (
  input  logic        ACLK,
  input  logic        ARSTn,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic [31:0] rf_addr,
  output logic [31:0] rf_data,
  output logic        rf_rw,
  input  logic [31:0] rf_rdata,
  input  logic [31:0] rf_r0,
  input  logic [31:0] rf_r1,
  output logic [2:0]  dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_RD_WAIT, S_RRSP, S_CALC, S_WB, S_BRSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] CNT_LAST    = 4'(CALC_CYCLES - 1);

  state_e      state_q, state_d;
  logic        awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d, rf_addr_q, rf_addr_d, rf_data_q, rf_data_d;
  logic        rf_rw_q, rf_rw_d;
  logic        busy_q, busy_d, done_q, done_d, carry_q, carry_d;
  logic        last_wr_q, last_wr_d;
  logic [1:0]  word_q, word_d;
  logic        err_q, err_d, start_q, start_d, clr_q, clr_d;
  logic [32:0] sum_q, sum_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_cand;
  logic        unused_addr_bits;

  assign wr_cand          = AWVALID && WVALID;
  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  // Handshakes: a READY is a registered one-cycle pulse issued only from IDLE; a
  // VALID is held with its payload stable until the matching READY is seen high.
  always_comb begin
    state_d   = state_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    arready_d = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    rf_rw_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    carry_d   = carry_q;
    last_wr_d = last_wr_q;
    word_d    = word_q;
    err_d     = err_q;
    start_d   = start_q;
    clr_d     = clr_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Regfile access is decided here so rf_rw lands in the WR/RD cycle itself.
        if (wr_cand && (!ARVALID || !last_wr_q)) begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
          last_wr_d = 1'b1;
          word_d    = AWADDR[3:2];
          err_d     = |AWADDR[31:4];
          start_d   = WDATA[0];
          clr_d     = WDATA[2];
          state_d   = S_WR;
          if (!(|AWADDR[31:4]) && AWADDR[3:2] != 2'd3) begin
            rf_rw_d   = 1'b1;
            rf_addr_d = {30'd0, AWADDR[3:2]};
            rf_data_d = WDATA;
          end
        end else if (ARVALID) begin
          arready_d = 1'b1;
          last_wr_d = 1'b0;
          word_d    = ARADDR[3:2];
          err_d     = |ARADDR[31:4];
          state_d   = S_RD;
          if (!(|ARADDR[31:4]) && ARADDR[3:2] != 2'd3) begin
            rf_addr_d = {30'd0, ARADDR[3:2]};
          end
        end
      end
      S_WR: begin
        bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
        bvalid_d = 1'b1;
        state_d  = S_BRSP;
        if (!err_q && word_q == 2'd3) begin
          if (clr_q) done_d = 1'b0;
          if (start_q) begin
            busy_d   = 1'b1;
            sum_d    = {1'b0, rf_r0} + {1'b0, rf_r1};
            cnt_d    = 4'd0;
            bvalid_d = 1'b0;
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_LAST) begin
          rf_rw_d   = 1'b1;
          rf_addr_d = 32'd2;
          rf_data_d = sum_q[31:0];
          state_d   = S_WB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WB: begin
        busy_d   = 1'b0;
        done_d   = 1'b1;
        carry_d  = sum_q[32];
        bresp_d  = RESP_OKAY;
        bvalid_d = 1'b1;
        state_d  = S_BRSP;
      end
      S_BRSP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_RD: begin
        rresp_d = err_q ? RESP_SLVERR : RESP_OKAY;
        if (err_q) begin
          rdata_d  = 32'd0;
          rvalid_d = 1'b1;
          state_d  = S_RRSP;
        end else if (word_q == 2'd3) begin
          rdata_d  = {28'd0, carry_q, done_q, busy_q, 1'b0};
          rvalid_d = 1'b1;
          state_d  = S_RRSP;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        rdata_d  = rf_rdata;
        rvalid_d = 1'b1;
        state_d  = S_RRSP;
      end
      S_RRSP: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      rf_rw_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      carry_q   <= 1'b0;
      last_wr_q <= 1'b0;
      word_q    <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      clr_q     <= 1'b0;
      sum_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      rf_rw_q   <= rf_rw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      carry_q   <= carry_d;
      last_wr_q <= last_wr_d;
      word_q    <= word_d;
      err_q     <= err_d;
      start_q   <= start_d;
      clr_q     <= clr_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign ARREADY   = arready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign RVALID    = rvalid_q;
  assign RRESP     = rresp_q;
  assign RDATA     = rdata_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign rf_rw     = rf_rw_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_regfile_axil_ctrl.sv
// Bench for regfile_axil_ctrl: behavioural regfile, AXI-Lite driver tasks and a
// reference model of the register map and add sequencer.
module tb_regfile_axil_ctrl;
  localparam int CALC_CYCLES = 3;

  logic        ACLK = 1'b0;
  logic        ARSTn = 1'b0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, rf_rw;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA, rf_addr, rf_data, rf_r0, rf_r1;
  logic [31:0] rf_rdata = '0;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] regs [3] = '{32'd0, 32'd0, 32'd0};
  logic [31:0] m_rf [3] = '{32'd0, 32'd0, 32'd0};
  logic        m_done = 1'b0;
  logic        m_carry = 1'b0;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] a;
    logic [31:0] d;
  } rfw_t;
  rfw_t        rfw_q[$];
  rfw_t        mon_e;
  logic [63:0] exp_q[$];

  regfile_axil_ctrl #(.CALC_CYCLES(CALC_CYCLES)) dut (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .rf_addr(rf_addr), .rf_data(rf_data), .rf_rw(rf_rw), .rf_rdata(rf_rdata),
    .rf_r0(rf_r0), .rf_r1(rf_r1), .dbg_state(dbg_state)
  );

  // clock / cycle count
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // external register file: registered read port, live r0/r1 views
  always @(posedge ACLK) begin
    if (rf_rw) begin
      if (rf_addr < 32'd3) regs[rf_addr[1:0]] <= rf_data;
    end else begin
      rf_rdata <= (rf_addr < 32'd3) ? regs[rf_addr[1:0]] : 32'd0;
    end
  end
  assign rf_r0 = regs[0];
  assign rf_r1 = regs[1];

  // every cycle with rf_rw high is logged
  always @(negedge ACLK) begin
    if (rf_rw) begin
      mon_e.c = 32'(cyc);
      mon_e.a = rf_addr;
      mon_e.d = rf_data;
      rfw_q.push_back(mon_e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic [1:0] resp, output int aw_c, output int b_c);
    int n;
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = addr; WVALID = 1'b1; WDATA = data; BREADY = 1'b1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 200) begin @(negedge ACLK); n++; end
    aw_c = cyc;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!BVALID && n < 200) begin @(negedge ACLK); n++; end
    b_c = cyc;
    resp = BVALID ? BRESP : 2'bxx;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdly, output logic [31:0] data,
                          output logic [1:0] resp, output int ar_c, output int r_c,
                          output bit stable);
    int n;
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = addr; RREADY = 1'b0;
    n = 0;
    while (!ARREADY && n < 200) begin @(negedge ACLK); n++; end
    ar_c = cyc;
    @(negedge ACLK);
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 200) begin @(negedge ACLK); n++; end
    r_c = cyc;
    data = RVALID ? RDATA : 32'hxxxxxxxx;
    resp = RVALID ? RRESP : 2'bxx;
    stable = RVALID;
    for (int i = 0; i < rdly; i++) begin
      @(negedge ACLK);
      if (!RVALID || RDATA !== data || RRESP !== resp) stable = 1'b0;
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ARSTn = 1'b0;
    repeat (3) @(negedge ACLK);
    total++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, rf_rw} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 000000", {AWREADY, WREADY, ARREADY, BVALID, RVALID, rf_rw});
    end
    total++;
    if ({BRESP, RRESP} !== 4'b0) begin bad++; $display("FAIL reset_resp: got %b want 0000", {BRESP, RRESP}); end
    total++;
    if (RDATA !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", RDATA); end
    total++;
    if ({rf_addr, rf_data} !== 64'd0) begin bad++; $display("FAIL reset_rf: got %h/%h want 0/0", rf_addr, rf_data); end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    ARSTn = 1'b1;
    repeat (2) @(negedge ACLK);
    total++;
    if ({AWREADY, ARREADY, rf_rw} !== 3'b0) begin
      bad++; $display("FAIL idle_no_req: got %b want 000", {AWREADY, ARREADY, rf_rw});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    logic [5:0]  order;
    int grants, n, rd_seen, rd_bad, b_seen;
    x = $urandom();
    order = '0; grants = 0; n = 0; rd_seen = 0; rd_bad = 0; b_seen = 0;
    @(negedge ACLK);
    AWVALID = 1'b1; WVALID = 1'b1; AWADDR = 32'h4; WDATA = x;
    ARVALID = 1'b1; ARADDR = 32'h4; BREADY = 1'b1; RREADY = 1'b1;
    while (grants < 6 && n < 300) begin
      @(negedge ACLK); n++;
      if (RVALID) begin rd_seen++; if (RDATA !== x) rd_bad++; end
      if (BVALID) b_seen++;
      if (AWREADY) begin order[grants] = 1'b1; grants++; end
      else if (ARREADY) begin order[grants] = 1'b0; grants++; end
    end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    if (RVALID) begin rd_seen++; if (RDATA !== x) rd_bad++; end
    if (BVALID) b_seen++;
    repeat (8) begin
      @(negedge ACLK);
      if (RVALID) begin rd_seen++; if (RDATA !== x) rd_bad++; end
      if (BVALID) b_seen++;
    end
    BREADY = 1'b0; RREADY = 1'b0;
    m_rf[1] = x;
    total++;
    if (order !== 6'b010101 || grants != 6) begin
      bad++; $display("FAIL rr_order: got %b (%0d grants) want 010101", order, grants);
    end
    total++;
    if (rd_seen != 3 || rd_bad != 0) begin
      bad++; $display("FAIL rr_reads: got %0d reads %0d wrong want 3 reads 0 wrong", rd_seen, rd_bad);
    end
    total++;
    if (b_seen != 3) begin bad++; $display("FAIL rr_bresp: got %0d want 3", b_seen); end
  endtask

  task automatic test_basic_rw();
    logic [1:0] resp; logic [31:0] d; int aw_c, b_c, ar_c, r_c, n0; bit st;
    n0 = rfw_q.size();
    axi_write(32'h0, 32'h10, resp, aw_c, b_c);
    m_rf[0] = 32'h10;
    total++;
    if (resp !== 2'b00) begin bad++; $display("FAIL basic_bresp: got %b want 00", resp); end
    total++;
    if (rfw_q.size() - n0 != 1) begin bad++; $display("FAIL basic_rw_cycles: got %0d want 1", rfw_q.size() - n0); end
    else begin
      total++;
      if (rfw_q[n0].a !== 32'd0 || rfw_q[n0].d !== 32'h10) begin
        bad++; $display("FAIL basic_rf_wr: got %h/%h want 0/10", rfw_q[n0].a, rfw_q[n0].d);
      end
    end
    axi_read(32'h0, 0, d, resp, ar_c, r_c, st);
    total++;
    if (d !== 32'h10 || resp !== 2'b00) begin bad++; $display("FAIL basic_read: got %h/%b want 10/00", d, resp); end
    total++;
    if (r_c - ar_c != 2) begin bad++; $display("FAIL basic_r_latency: got %0d want 2", r_c - ar_c); end
  endtask

  task automatic test_calc();
    logic [1:0] resp; logic [31:0] d; int aw_c, b_c, ar_c, r_c, n0; bit st;
    axi_write(32'h0, 32'd5, resp, aw_c, b_c); m_rf[0] = 32'd5;
    axi_write(32'h4, 32'd7, resp, aw_c, b_c); m_rf[1] = 32'd7;
    n0 = rfw_q.size();
    axi_write(32'hC, 32'h1, resp, aw_c, b_c);
    m_rf[2] = 32'd12; m_done = 1'b1; m_carry = 1'b0;
    total++;
    if (resp !== 2'b00) begin bad++; $display("FAIL calc_bresp: got %b want 00", resp); end
    total++;
    if (rfw_q.size() - n0 != 1) begin bad++; $display("FAIL calc_rf_count: got %0d want 1", rfw_q.size() - n0); end
    else begin
      total++;
      if (rfw_q[n0].a !== 32'd2 || rfw_q[n0].d !== 32'd12) begin
        bad++; $display("FAIL calc_rf_wr: got %h/%h want 2/c", rfw_q[n0].a, rfw_q[n0].d);
      end
      total++;
      if (int'(rfw_q[n0].c) - aw_c != CALC_CYCLES + 1) begin
        bad++; $display("FAIL calc_wb_time: got %0d want %0d", int'(rfw_q[n0].c) - aw_c, CALC_CYCLES + 1);
      end
      total++;
      if (b_c - int'(rfw_q[n0].c) != 1) begin
        bad++; $display("FAIL calc_b_time: got %0d want 1", b_c - int'(rfw_q[n0].c));
      end
    end
    axi_read(32'hC, 0, d, resp, ar_c, r_c, st);
    total++;
    if (d !== 32'h4 || resp !== 2'b00) begin bad++; $display("FAIL calc_status: got %h/%b want 4/00", d, resp); end
  endtask

  task automatic test_carry_wrap();
    logic [1:0] resp; logic [31:0] d; int aw_c, b_c, ar_c, r_c; bit st;
    axi_write(32'h0, 32'hFFFF_FFFF, resp, aw_c, b_c); m_rf[0] = 32'hFFFF_FFFF;
    axi_write(32'h4, 32'h1, resp, aw_c, b_c); m_rf[1] = 32'h1;
    axi_write(32'hC, 32'h5, resp, aw_c, b_c);
    m_rf[2] = 32'd0; m_done = 1'b1; m_carry = 1'b1;
    axi_read(32'h8, 0, d, resp, ar_c, r_c, st);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL wrap_r2: got %h want 0", d); end
    axi_read(32'hC, 0, d, resp, ar_c, r_c, st);
    total++;
    if (d !== 32'hC) begin bad++; $display("FAIL wrap_status: got %h want c", d); end
    axi_write(32'hC, 32'h4, resp, aw_c, b_c);
    m_done = 1'b0;
    axi_read(32'hC, 0, d, resp, ar_c, r_c, st);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL done_clear: got %h want 8", d); end
  endtask

  task automatic test_error();
    logic [1:0] resp; logic [31:0] d; int aw_c, b_c, ar_c, r_c, n0; bit st;
    axi_read(32'h20, 5, d, resp, ar_c, r_c, st);
    total++;
    if (resp !== 2'b10 || d !== 32'd0) begin bad++; $display("FAIL err_read: got %h/%b want 0/10", d, resp); end
    total++;
    if (st !== 1'b1) begin bad++; $display("FAIL err_r_stable: got %b want 1", st); end
    n0 = rfw_q.size();
    axi_write(32'h20, $urandom(), resp, aw_c, b_c);
    total++;
    if (resp !== 2'b10) begin bad++; $display("FAIL err_write: got %b want 10", resp); end
    total++;
    if (rfw_q.size() != n0) begin bad++; $display("FAIL err_no_rf: got %0d want 0", rfw_q.size() - n0); end
  endtask

  task automatic test_random();
    logic [1:0] resp, exp_resp; logic [31:0] d, exp_d, addr, data; logic [32:0] s;
    logic [1:0] w; bit err, st; int aw_c, b_c, ar_c, r_c, n0;
    for (int i = 0; i < 40; i++) begin
      w = 2'($urandom_range(0, 3));
      err = ($urandom_range(0, 7) == 0);
      addr = {err ? 28'($urandom_range(1, 32'h0FFF_FFFF)) : 28'd0, w, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) < 5) begin
        data = (w == 2'd3) ? 32'($urandom_range(0, 7)) : $urandom();
        exp_q.delete();
        exp_resp = err ? 2'b10 : 2'b00;
        if (!err && w != 2'd3) begin
          m_rf[w] = data; exp_q.push_back({30'd0, w, data});
        end else if (!err) begin
          if (data[2]) m_done = 1'b0;
          if (data[0]) begin
            s = {1'b0, m_rf[0]} + {1'b0, m_rf[1]};
            m_rf[2] = s[31:0]; m_carry = s[32]; m_done = 1'b1;
            exp_q.push_back({32'd2, s[31:0]});
          end
        end
        n0 = rfw_q.size();
        axi_write(addr, data, resp, aw_c, b_c);
        total++;
        if (resp !== exp_resp) begin bad++; $display("FAIL rnd_bresp[%0d]: got %b want %b", i, resp, exp_resp); end
        total++;
        if (rfw_q.size() - n0 != exp_q.size()) begin
          bad++; $display("FAIL rnd_rf_count[%0d]: got %0d want %0d", i, rfw_q.size() - n0, exp_q.size());
        end else if (exp_q.size() == 1) begin
          total++;
          if ({rfw_q[n0].a, rfw_q[n0].d} !== exp_q[0]) begin
            bad++; $display("FAIL rnd_rf_wr[%0d]: got %h want %h", i, {rfw_q[n0].a, rfw_q[n0].d}, exp_q[0]);
          end
        end
      end else begin
        exp_resp = err ? 2'b10 : 2'b00;
        exp_d = err ? 32'd0 : (w == 2'd3) ? {28'd0, m_carry, m_done, 2'b00} : m_rf[w];
        axi_read(addr, $urandom_range(0, 2), d, resp, ar_c, r_c, st);
        total++;
        if (d !== exp_d || resp !== exp_resp) begin
          bad++; $display("FAIL rnd_read[%0d] @%h: got %h/%b want %h/%b", i, addr, d, resp, exp_d, exp_resp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] d, x; logic [32:0] s; int aw_c, b_c, ar_c, r_c, n, n0; bit st;
    // reset while a B response is being held
    x = $urandom();
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'h0; WVALID = 1'b1; WDATA = x; BREADY = 1'b0;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    m_rf[0] = x;
    total++;
    if (BVALID !== 1'b1) begin bad++; $display("FAIL bhold_pre: got %b want 1", BVALID); end
    #2 ARSTn = 1'b0;
    #1;
    total++;
    if (BVALID !== 1'b0 || dbg_state !== 3'd0) begin
      bad++; $display("FAIL async_bvalid: got %b/%0d want 0/0", BVALID, dbg_state);
    end
    @(negedge ACLK);
    ARSTn = 1'b1;
    m_done = 1'b0; m_carry = 1'b0;
    // reset during CALC: sum must never reach r2
    axi_write(32'hC, 32'h1, resp, aw_c, b_c);
    s = {1'b0, m_rf[0]} + {1'b0, m_rf[1]};
    m_rf[2] = s[31:0]; m_carry = s[32]; m_done = 1'b1;
    axi_read(32'hC, 0, d, resp, ar_c, r_c, st);
    total++;
    if (d !== {28'd0, m_carry, m_done, 2'b00}) begin
      bad++; $display("FAIL pre_status: got %h want %h", d, {28'd0, m_carry, m_done, 2'b00});
    end
    axi_write(32'h4, m_rf[1] + 32'd3, resp, aw_c, b_c);
    m_rf[1] = m_rf[1] + 32'd3;
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'hC; WVALID = 1'b1; WDATA = 32'h1;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    n0 = rfw_q.size();
    #2 ARSTn = 1'b0;
    #1;
    total++;
    if (BVALID !== 1'b0 || rf_rw !== 1'b0 || dbg_state !== 3'd0) begin
      bad++; $display("FAIL calc_reset: got %b/%b/%0d want 0/0/0", BVALID, rf_rw, dbg_state);
    end
    repeat (2) @(negedge ACLK);
    ARSTn = 1'b1;
    m_done = 1'b0; m_carry = 1'b0;
    repeat (8) @(negedge ACLK);
    total++;
    if (rfw_q.size() != n0) begin bad++; $display("FAIL calc_reset_no_wb: got %0d want 0", rfw_q.size() - n0); end
    axi_read(32'h8, 0, d, resp, ar_c, r_c, st);
    total++;
    if (d !== m_rf[2]) begin bad++; $display("FAIL calc_reset_r2: got %h want %h", d, m_rf[2]); end
    axi_read(32'hC, 0, d, resp, ar_c, r_c, st);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL calc_reset_status: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_basic_rw();
    test_calc();
    test_carry_wrap();
    test_error();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_axil_ctrl.md
Name: regfile_axil_ctrl

Overview:
- AXI4-Lite slave front end and sequencer for the 3-entry operand/result register file (r0 = operand A, r1 = operand B, r2 = sum).
- Arbitrates bus writes and bus reads onto the single regfile port (addr_in/data_in/rw/data_out).
- Owns a control/status word at word 3 that launches an add of r0+r1, waits CALC_CYCLES cycles, then writes the sum into r2.

Parameters:
- CALC_CYCLES, 1, wait cycles between operand sample and r2 writeback (1..15).

Ports:
- ACLK  in  1  clock.
- ARSTn  in  1  reset, asynchronous, active-low.
- AWVALID / AWREADY  in/out  1/1  write address handshake.
- AWADDR  in  32  byte address.
- WVALID / WREADY  in/out  1/1  write data handshake.
- WDATA  in  32  write data (no strobes; full-word writes only).
- BVALID / BREADY  out/in  1/1  write response handshake.
- BRESP  out  2  00 OKAY, 10 SLVERR.
- ARVALID / ARREADY  in/out  1/1  read address handshake.
- ARADDR  in  32  byte address.
- RVALID / RREADY  out/in  1/1  read response handshake.
- RDATA  out  32  read data.
- RRESP  out  2  00 OKAY, 10 SLVERR.
- rf_addr  out  32  regfile word index 0..2.
- rf_data  out  32  regfile write data.
- rf_rw  out  1  0 read, 1 write.
- rf_rdata  in  32  regfile data_out, registered, valid 1 cycle after a read issue.
- rf_r0, rf_r1  in  32/32  live operand views.

Behaviour:
- Address map (word = ADDR[3:2], ADDR[1:0] ignored):
  - 0/1/2 map to regfile entries.
  - 3 = CTRL: bit0 START (W, reads 0), bit1 BUSY (RO), bit2 DONE (sticky, write 1 clears), bit3 CARRY (RO, from last add).
  - ADDR[31:4] != 0 -> SLVERR, no regfile access, RDATA = 0.
- All outputs registered. Reset (async) values: every VALID/READY 0, BRESP/RRESP 00, RDATA 0, rf_addr 0, rf_data 0, rf_rw 0, status bits 0, round-robin pointer = "read last", FSM IDLE.
- When no write is issued, rf_rw = 0. rf_rw = 1 for exactly one cycle per regfile write.
- FSM states: IDLE, WR, RD, RD_WAIT, RRSP, CALC, WB, BRSP.
- IDLE:
  - Write candidate requires AWVALID & WVALID. Read candidate requires ARVALID.
  - Both candidates present -> grant the one not granted last (round-robin). Only one present -> grant it.
  - Write grant: pulse AWREADY & WREADY for 1 cycle, latch address/data, go to WR.
  - Read grant: pulse ARREADY for 1 cycle, latch address, go to RD.
- WR:
  - Word 0..2: rf_rw = 1, rf_addr = word, rf_data = WDATA -> BRSP.
  - Word 3: apply DONE clear. If START = 1, set BUSY, latch {CARRY, sum} = rf_r0 + rf_r1 (33-bit) -> CALC. Otherwise -> BRSP.
  - Error address -> BRSP with SLVERR.
- CALC: counter runs CALC_CYCLES cycles, then -> WB.
- WB: rf_rw = 1, rf_addr = 2, rf_data = sum. Clear BUSY, set DONE and CARRY. -> BRSP.
  - The B response to a START write therefore arrives only after r2 is written.
- BRSP: BVALID held until BREADY; BVALID drops the cycle after the handshake -> IDLE.
- RD: word 0..2 issue rf_rw = 0, rf_addr = word -> RD_WAIT. Word 3 or error skips to RRSP with status/0.
- RD_WAIT: capture rf_rdata into RDATA -> RRSP.
- RRSP: RVALID and RDATA held stable until RREADY -> IDLE.
- Boundary cases:
  - Sum wrap: 0xFFFFFFFF + 1 -> r2 = 0, CARRY = 1.
  - START written with bit2 = 1 in the same write: DONE is cleared first, then set again at WB.
  - Bus requests arriving during CALC/WB stall; no READY is asserted until IDLE.
  - AW without W (or W without AW) is never granted.
  - Reset mid-operation: the transaction is dropped, all VALIDs drop immediately, BUSY/DONE are cleared, and no regfile write is issued.

Test Plan:
- Write 0x10 to addr 0x0, then read 0x0 -> OKAY. RDATA = 0x10. rf_rw high exactly 1 cycle. RVALID 2 cycles after the ARREADY cycle.
- r0 = 5, r1 = 7, write 0x1 to 0xC with CALC_CYCLES = 3 -> rf write of 12 to addr 2 exactly 4 cycles after WR. BVALID the cycle after. Reading 0xC returns 0x4.
- r0 = 0xFFFFFFFF, r1 = 1, START -> r2 = 0. Status read = 0xC. Then write 0x4 to 0xC -> status = 0x8.
- AW/W and AR valid together in back-to-back requests -> grants alternate write, read, write, starting with write after reset.
- Read of 0x20 -> RRESP = 10, RDATA = 0. Write of 0x20 -> BRESP = 10, rf_rw never asserted. RREADY held low for 5 cycles -> RVALID/RDATA stable throughout.
- ARSTn pulled low during CALC -> BVALID = 0 asynchronously, no r2 write, status reads 0 after reset release.
